// File: rtl/rcc_lse_ctrl.sv
// rcc_lse_ctrl
//   LSE oscillator controller for the RCC backup domain. It sequences the LSE
//   crystal/bypass enables from the BDCR control bits. It qualifies oscillator
//   start-up by counting synchronized LSE edges before raising lserdy. It also
//   runs the LSE clock security system (CSS) watchdog in RUN.
//
//   Optional feature macro: RCC_LSE_CSS_EN
//     defined   : the watchdog, the FAIL state, lsecss_fail and lsecss_irq are built.
//     undefined : none of them are built; lsecss_fail and lsecss_irq are tied
//                 to 0, and lsecsson and CSS_WIN are ignored.
//
//   Ports
//     clk          in   RCC clock
//     rst          in   synchronous reset, active-high
//     lseon        in   LSE enable (BDCR)
//     lsebyp       in   bypass select (BDCR), sampled on OFF->WAIT only
//     lsedrv[1:0]  in   drive strength (BDCR), sampled on OFF->WAIT only
//     lsecsson     in   CSS enable (BDCR)
//     lse_tick     in   one-clk pulse per synchronized LSE rising edge
//     lse_osc_en   out  crystal oscillator enable
//     lse_byp_en   out  bypass buffer enable
//     lserdy       out  LSE ready
//     lsecss_fail  out  CSS failure level
//     lsecss_irq   out  one-cycle pulse on CSS failure
//
//   All outputs are registered decodes of the current state. Every output
//   change therefore appears one edge after the state transition that causes it.

module rcc_lse_ctrl #(
  parameter int unsigned STARTUP_TICKS = 64,
  parameter int unsigned BYP_TICKS     = 4,
  parameter int unsigned CSS_WIN       = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lseon,
  input  logic       lsebyp,
  input  logic [1:0] lsedrv,
  input  logic       lsecsson,
  input  logic       lse_tick,
  output logic       lse_osc_en,
  output logic       lse_byp_en,
  output logic       lserdy,
  output logic       lsecss_fail,
  output logic       lsecss_irq
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_WAIT,
    ST_RUN
`ifdef RCC_LSE_CSS_EN
    , ST_FAIL
`endif
  } state_t;

  state_t           state;
  logic             byp_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_load;
  logic [31:0]      xtal_ticks;

  // Start-up tick count, chosen at the OFF->WAIT transition.
  always_comb begin
    xtal_ticks = STARTUP_TICKS >> lsedrv;
    if (lsebyp)
      n_load = CNT_W'(BYP_TICKS);
    else if (xtal_ticks == 32'd0)
      n_load = CNT_W'(1);
    else
      n_load = CNT_W'(xtal_ticks);
  end

`ifdef RCC_LSE_CSS_EN
  logic [CNT_W-1:0] wd;
`else
  logic unused_css;
  assign unused_css  = lsecsson ^ (CSS_WIN == 0);
  assign lsecss_fail = 1'b0;
  assign lsecss_irq  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_OFF;
      byp_q      <= 1'b0;
      cnt        <= '0;
      lse_osc_en <= 1'b0;
      lse_byp_en <= 1'b0;
      lserdy     <= 1'b0;
`ifdef RCC_LSE_CSS_EN
      wd          <= '0;
      lsecss_fail <= 1'b0;
      lsecss_irq  <= 1'b0;
`endif
    end else begin
      // Registered output decode of the current state.
      lse_osc_en <= 1'b0;
      lse_byp_en <= 1'b0;
      lserdy     <= 1'b0;
`ifdef RCC_LSE_CSS_EN
      lsecss_fail <= 1'b0;
      lsecss_irq  <= 1'b0;
`endif
      case (state)
        ST_WAIT: begin
          lse_osc_en <= ~byp_q;
          lse_byp_en <= byp_q;
        end
        ST_RUN: begin
          lse_osc_en <= ~byp_q;
          lse_byp_en <= byp_q;
          lserdy     <= 1'b1;
        end
`ifdef RCC_LSE_CSS_EN
        ST_FAIL: begin
          lsecss_fail <= 1'b1;
          // The level is still low only in the first FAIL cycle.
          lsecss_irq  <= ~lsecss_fail;
        end
`endif
        default: ;
      endcase

      // Next-state logic. lseon=0 has priority over ticks and expiry.
      case (state)
        ST_OFF: begin
          if (lseon) begin
            state <= ST_WAIT;
            byp_q <= lsebyp;
            cnt   <= n_load;
          end
        end
        ST_WAIT: begin
          if (!lseon) begin
            state <= ST_OFF;
          end else if (lse_tick) begin
            if (cnt == CNT_W'(1)) begin
              state <= ST_RUN;
`ifdef RCC_LSE_CSS_EN
              wd    <= '0;
`endif
            end
            if (cnt != '0)
              cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lseon) begin
            state <= ST_OFF;
          end
`ifdef RCC_LSE_CSS_EN
          // A tick in the expiry cycle wins, so no failure is raised.
          else if (!lsecsson || lse_tick) begin
            wd <= '0;
          end else if (wd == CNT_W'(CSS_WIN - 1)) begin
            state <= ST_FAIL;
          end else begin
            wd <= wd + CNT_W'(1);
          end
`endif
        end
`ifdef RCC_LSE_CSS_EN
        ST_FAIL: begin
          if (!lseon)
            state <= ST_OFF;
        end
`endif
        default: state <= ST_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_rcc_lse_ctrl.sv
// Bench for rcc_lse_ctrl with STARTUP_TICKS=8, BYP_TICKS=2, CSS_WIN=5.
// Inputs are driven at the falling edge. Outputs are compared at the falling
// edge after each rising edge.
// The compared output vector is {lse_osc_en, lse_byp_en, lserdy, lsecss_fail, lsecss_irq}.

module tb_rcc_lse_ctrl;

  localparam int unsigned STARTUP_TICKS = 8;
  localparam int unsigned BYP_TICKS     = 2;
  localparam int unsigned CSS_WIN       = 5;
  localparam int unsigned CNT_W         = 16;

`ifdef RCC_LSE_CSS_EN
  localparam bit CSS = 1'b1;
`else
  localparam bit CSS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, lseon, lsebyp, lsecsson, lse_tick;
  logic [1:0] lsedrv;
  logic       lse_osc_en, lse_byp_en, lserdy, lsecss_fail, lsecss_irq;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  rcc_lse_ctrl #(
    .STARTUP_TICKS(STARTUP_TICKS),
    .BYP_TICKS    (BYP_TICKS),
    .CSS_WIN      (CSS_WIN),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lseon      (lseon),
    .lsebyp     (lsebyp),
    .lsedrv     (lsedrv),
    .lsecsson   (lsecsson),
    .lse_tick   (lse_tick),
    .lse_osc_en (lse_osc_en),
    .lse_byp_en (lse_byp_en),
    .lserdy     (lserdy),
    .lsecss_fail(lsecss_fail),
    .lsecss_irq (lsecss_irq)
  );

  typedef struct {
    logic       rst;
    logic       lseon;
    logic       lsebyp;
    logic [1:0] lsedrv;
    logic       lsecsson;
    logic       lse_tick;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [4:0] outs();
    return {lse_osc_en, lse_byp_en, lserdy, lsecss_fail, lsecss_irq};
  endfunction

  task automatic add(input logic r, input logic on, input logic byp,
                     input logic [1:0] drv, input logic css, input logic tk,
                     input logic [4:0] e);
    vec_t v;
    v.rst = r; v.lseon = on; v.lsebyp = byp; v.lsedrv = drv;
    v.lsecsson = css; v.lse_tick = tk; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic on, input logic byp,
                      input logic [1:0] drv, input logic css, input logic tk);
    rst = r; lseon = on; lsebyp = byp; lsedrv = drv; lsecsson = css; lse_tick = tk;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [4:0] e);
    logic [4:0] got;
    got = outs();
    n_total++;
    if (got === e)
      n_pass++;
    else
      $display("FAIL %s: got %b expected %b (osc,byp,rdy,fail,irq)", name, got, e);
  endtask

  initial begin
    rst = 1'b1; lseon = 1'b0; lsebyp = 1'b0; lsedrv = 2'd0;
    lsecsson = 1'b0; lse_tick = 1'b0;

    //   rst on  byp drv  css tick expected
    add(1, 0, 0, 2'd0, 0, 0, 5'b00000);  // reset state
    add(1, 1, 0, 2'd2, 0, 0, 5'b00000);  // reset beats lseon
    // crystal, lsedrv=2 -> N=2, ticks every 3 cycles
    add(0, 1, 0, 2'd2, 0, 0, 5'b00000);  // OFF->WAIT
    add(0, 1, 0, 2'd2, 0, 0, 5'b10000);  // osc enable one cycle later
    add(0, 1, 0, 2'd2, 0, 1, 5'b10000);  // tick 1
    add(0, 1, 0, 2'd0, 0, 0, 5'b10000);  // late lsedrv change ignored
    add(0, 1, 0, 2'd0, 0, 0, 5'b10000);
    add(0, 1, 0, 2'd0, 0, 1, 5'b10000);  // tick 2 -> RUN
    add(0, 1, 0, 2'd0, 0, 0, 5'b10100);  // lserdy
    add(0, 0, 0, 2'd0, 0, 0, 5'b10100);  // lseon falls
    add(0, 0, 0, 2'd0, 0, 0, 5'b00000);  // all off
    // bypass, lsedrv=3 -> N=BYP_TICKS=2
    add(0, 1, 1, 2'd3, 0, 0, 5'b00000);
    add(0, 1, 1, 2'd3, 0, 1, 5'b01000);
    add(0, 1, 0, 2'd3, 0, 0, 5'b01000);  // late lsebyp change ignored
    add(0, 1, 0, 2'd3, 0, 1, 5'b01000);
    add(0, 1, 0, 2'd3, 0, 0, 5'b01100);
    add(0, 0, 0, 2'd3, 0, 0, 5'b01100);
    // crystal, lsedrv=3 -> N=1
    add(0, 1, 0, 2'd3, 0, 0, 5'b00000);
    add(0, 1, 0, 2'd3, 0, 1, 5'b10000);
    add(0, 1, 0, 2'd3, 0, 0, 5'b10100);
    add(0, 0, 0, 2'd3, 0, 0, 5'b10100);
    // abort in WAIT, then re-enable reloads N=4 (lsedrv=1)
    add(0, 1, 0, 2'd1, 0, 0, 5'b00000);
    add(0, 1, 0, 2'd1, 0, 1, 5'b10000);  // one tick counted
    add(0, 0, 0, 2'd1, 0, 1, 5'b10000);  // lseon=0 beats tick
    add(0, 0, 0, 2'd1, 0, 0, 5'b00000);
    add(0, 1, 0, 2'd1, 0, 0, 5'b00000);  // re-enable
    add(0, 1, 0, 2'd1, 0, 1, 5'b10000);
    add(0, 1, 0, 2'd1, 0, 1, 5'b10000);
    add(0, 1, 0, 2'd1, 0, 1, 5'b10000);  // 3 of 4 ticks
    add(0, 1, 0, 2'd1, 0, 0, 5'b10000);  // still not ready
    add(0, 1, 0, 2'd1, 0, 1, 5'b10000);  // 4th tick -> RUN
    add(0, 1, 0, 2'd1, 0, 0, 5'b10100);
    // CSS off: long tick-free gap must not fail
    for (int i = 0; i < 7; i++)
      add(0, 1, 0, 2'd1, 0, 0, 5'b10100);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].lseon, vecs[i].lsebyp, vecs[i].lsedrv,
           vecs[i].lsecsson, vecs[i].lse_tick);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // CSS edge case followed by real expiry (state is RUN, crystal)
    step(0, 1, 0, 2'd0, 1, 1); check("css_arm", 5'b10100);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 2'd0, 1, 0); check("css_gap", 5'b10100);
    end
    step(0, 1, 0, 2'd0, 1, 1); check("css_edge_tick", 5'b10100);  // wd==4 + tick
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 2'd0, 1, 0); check("css_no_fail_yet", 5'b10100);
    end
    step(0, 1, 0, 2'd0, 1, 0); check("css_fail_irq",    CSS ? 5'b00011 : 5'b10100);
    step(0, 1, 0, 2'd0, 1, 0); check("css_fail_hold",   CSS ? 5'b00010 : 5'b10100);
    step(0, 1, 0, 2'd0, 0, 1); check("css_fail_sticky", CSS ? 5'b00010 : 5'b10100);
    step(0, 0, 0, 2'd0, 0, 0); check("css_off_edge",    CSS ? 5'b00010 : 5'b10100);
    step(0, 0, 0, 2'd0, 0, 0); check("css_off",         5'b00000);

    // lsecsson falling in RUN clears the watchdog (bypass bring-up)
    step(0, 1, 1, 2'd0, 1, 0); check("b_wait_entry", 5'b00000);
    step(0, 1, 1, 2'd0, 1, 1); check("b_tick1", 5'b01000);
    step(0, 1, 1, 2'd0, 1, 1); check("b_tick2", 5'b01000);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 2'd0, 1, 0); check("b_run_gap", 5'b01100);
    end
    step(0, 1, 1, 2'd0, 0, 0); check("b_css_off", 5'b01100);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 2'd0, 1, 0); check("b_wd_restart", 5'b01100);
    end
    step(0, 1, 1, 2'd0, 1, 0); check("b_fail", CSS ? 5'b00011 : 5'b01100);

    // reset in FAIL (or RUN when CSS is not built)
    step(1, 1, 1, 2'd0, 1, 0); check("rst_in_fail", 5'b00000);
    step(0, 0, 0, 2'd0, 0, 0); check("rst_after", 5'b00000);

    // reset in RUN
    step(0, 1, 0, 2'd3, 0, 0); check("r_wait_entry", 5'b00000);
    step(0, 1, 0, 2'd3, 0, 1); check("r_tick", 5'b10000);
    step(0, 1, 0, 2'd3, 0, 0); check("r_run", 5'b10100);
    step(1, 1, 0, 2'd3, 0, 0); check("rst_in_run", 5'b00000);
    step(0, 1, 0, 2'd3, 0, 0); check("r_restart_off", 5'b00000);
    step(0, 1, 0, 2'd3, 0, 0); check("r_restart_wait", 5'b10000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
